// File: rtl/axi_rom_responder_pkg.sv
// Shared encodings and state type for the AXI instruction-fetch ROM responder.
package axi_rom_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only full 32-bit word transfers are served.
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // Wrapping bursts must span a power-of-two number of beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_rom_ram.sv
// Word RAM: one synchronous read port (1-cycle, read-first) and one write port.
module axi_rom_ram #(
  parameter int unsigned AddrW = 14,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i
);

  logic [DataW-1:0] mem_q [2**AddrW];

  // rdata_o only changes on a read, so a stalled beat keeps its data.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

endmodule

// File: rtl/axi_rom_responder.sv
// AXI4 read-only slave serving burst reads from a loadable word RAM.
// Define SASANQUA_AXI_WRAP_EN to support WRAP bursts; otherwise they return SLVERR.
module axi_rom_responder
  import axi_rom_responder_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_ID_WIDTH   = 4,
  parameter int unsigned C_OFFSET_WIDTH   = 16,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h2000_0000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]   ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]                  ARLEN,
  input  logic [2:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]   RID,
  output logic [C_AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  input  logic                        LOAD_WE,
  input  logic [C_OFFSET_WIDTH-3:0]   LOAD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0] LOAD_DATA
);

  localparam int unsigned IdxW = C_OFFSET_WIDTH - 2;
  localparam logic [C_AXI_ADDR_WIDTH-1:0] AddrStep = 4;

  state_e                      state_q, state_d;
  logic                        arready_q;
  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [7:0]                  len_q, cnt_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;

  logic ar_hs, r_hs, last, burst_ok, slv_err, in_range;
  logic [C_AXI_ADDR_WIDTH-1:0] ar_off, nxt_off, cur_off;
  logic [IdxW-1:0]             ram_raddr;
  logic [C_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic                        ram_re;

  assign ar_hs = ARVALID & arready_q;
  assign r_hs  = (state_q == StBurst) & RREADY;
  assign last  = (cnt_q == 8'd0);

`ifdef SASANQUA_AXI_WRAP_EN
  logic [C_AXI_ADDR_WIDTH-1:0] wrap_mask;
  always_comb begin
    wrap_mask       = '0;
    wrap_mask[9:0]  = {len_q, 2'b11};
  end
`endif

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      BURST_INCR: addr_nxt = addr_q + AddrStep;
      BURST_WRAP: begin
`ifdef SASANQUA_AXI_WRAP_EN
        addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + AddrStep) & wrap_mask);
`endif
      end
      default: addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    burst_ok = 1'b0;
    case (burst_q)
      BURST_FIXED, BURST_INCR: burst_ok = 1'b1;
      BURST_WRAP: begin
`ifdef SASANQUA_AXI_WRAP_EN
        burst_ok = wrap_len_ok(len_q);
`else
        burst_ok = 1'b0;
`endif
      end
      default: burst_ok = 1'b0;
    endcase
  end

  // Range is checked per beat against the current beat address.
  assign slv_err  = (size_q != SIZE_WORD) | ~burst_ok;
  assign cur_off  = addr_q - C_BASE_ADDR;
  assign in_range = (addr_q >= C_BASE_ADDR) &&
                    (cur_off[C_AXI_ADDR_WIDTH-1:C_OFFSET_WIDTH] == '0);

  assign ar_off    = ARADDR - C_BASE_ADDR;
  assign nxt_off   = addr_nxt - C_BASE_ADDR;
  assign ram_re    = ar_hs | (r_hs & ~last);
  assign ram_raddr = ar_hs ? ar_off[C_OFFSET_WIDTH-1:2] : nxt_off[C_OFFSET_WIDTH-1:2];

  axi_rom_ram #(
    .AddrW (IdxW),
    .DataW (C_AXI_DATA_WIDTH)
  ) u_ram (
    .clk_i   (CLK),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata),
    .we_i    (LOAD_WE),
    .waddr_i (LOAD_ADDR),
    .wdata_i (LOAD_DATA)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ar_hs) state_d = StBurst;
      StBurst: if (r_hs && last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == StIdle);
      if (ar_hs) begin
        id_q    <= ARID;
        addr_q  <= ARADDR;
        len_q   <= ARLEN;
        cnt_q   <= ARLEN;
        size_q  <= ARSIZE;
        burst_q <= ARBURST;
      end else if (r_hs) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    ARREADY = arready_q;
    RVALID  = (state_q == StBurst);
    RID     = id_q;
    RLAST   = RVALID & last;
    RRESP   = RESP_OKAY;
    if (RVALID) begin
      if (slv_err)       RRESP = RESP_SLVERR;
      else if (!in_range) RRESP = RESP_DECERR;
    end
    RDATA = (RVALID && RRESP == RESP_OKAY) ? ram_rdata : '0;
  end

  logic unused_bits;
  assign unused_bits = ^{ar_off[1:0], ar_off[C_AXI_ADDR_WIDTH-1:C_OFFSET_WIDTH],
                         nxt_off[1:0], nxt_off[C_AXI_ADDR_WIDTH-1:C_OFFSET_WIDTH],
                         cur_off[C_OFFSET_WIDTH-1:0], len_q};

endmodule

// File: tb/tb_axi_rom_responder.sv
// Directed self-checking bench for axi_rom_responder (WRAP results follow SASANQUA_AXI_WRAP_EN).
module tb_axi_rom_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        LOAD_WE = 1'b0;
  logic [13:0] LOAD_ADDR = '0;
  logic [31:0] LOAD_DATA = '0;

  always #5 CLK = ~CLK;

  axi_rom_responder dut (
    .CLK       (CLK),
    .RST       (RST),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .LOAD_WE   (LOAD_WE),
    .LOAD_ADDR (LOAD_ADDR),
    .LOAD_DATA (LOAD_DATA)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bd[$];
  logic [1:0]  br[$];
  logic        bl[$];
  logic [3:0]  bid[$];
  int          bcyc[$];
  bit          timeout, ar_ok;
  int          unstable, arready_bad;

  task automatic load_word(input logic [13:0] idx, input logic [31:0] data);
    LOAD_WE = 1'b1; LOAD_ADDR = idx; LOAD_DATA = data;
    @(negedge CLK);
    LOAD_WE = 1'b0;
  endtask

  // Issues one AR and collects every accepted beat; called at a falling edge.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
    logic [34:0] hold;
    bit held, done;
    int cyc;
    bd.delete(); br.delete(); bl.delete(); bid.delete(); bcyc.delete();
    unstable = 0; arready_bad = 0; held = 0; done = 0; hold = '0;
    ar_ok = (ARREADY === 1'b1);
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    @(negedge CLK);
    ARVALID = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (held && hold !== {RLAST, RRESP, RDATA}) unstable++;
      held = 0;
      if (ARREADY !== 1'b0) arready_bad++;
      RREADY = stall ? (cyc % 2 == 1) : 1'b1;
      if (RVALID === 1'b1) begin
        if (RREADY) begin
          bd.push_back(RDATA); br.push_back(RRESP); bl.push_back(RLAST);
          bid.push_back(RID); bcyc.push_back(cyc);
          done = (RLAST === 1'b1);
        end else begin
          held = 1; hold = {RLAST, RRESP, RDATA};
        end
      end
      @(negedge CLK);
      cyc++;
    end
    RREADY = 1'b0;
    timeout = !done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    vectors++;
    if ({ARREADY, RVALID, RLAST, RRESP, RID, RDATA} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ar=%b rv=%b rl=%b resp=%b id=%h data=%h want all 0",
               ARREADY, RVALID, RLAST, RRESP, RID, RDATA);
    end
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ar=%b rv=%b want ar=1 rv=0", ARREADY, RVALID);
    end
  endtask

  task automatic test_incr();
    logic [38:0] exp;
    for (int i = 0; i < 8; i++) load_word(14'(i), 32'(32'h1000 + i));
    run_burst(4'h5, 32'h2000_0000, 8'd7, 3'b010, 2'b01, 1'b0);
    vectors++;
    if (timeout || !ar_ok || bd.size() != 8) begin
      miscompares++;
      $display("FAIL incr_count: got %0d beats timeout=%0b ar_ok=%0b want 8 beats",
               bd.size(), timeout, ar_ok);
    end
    for (int i = 0; i < 8 && i < bd.size(); i++) begin
      exp = {4'h5, (i == 7), 2'b00, 32'(32'h1000 + i)};
      vectors++;
      if ({bid[i], bl[i], br[i], bd[i]} !== exp || bcyc[i] != i + 1) begin
        miscompares++;
        $display("FAIL incr_beat%0d: got id/last/resp/data=%h cyc=%0d want %h cyc=%0d",
                 i, {bid[i], bl[i], br[i], bd[i]}, bcyc[i], exp, i + 1);
      end
    end
    vectors++;
    if (ARREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL incr_arready_after: got %b want 1", ARREADY);
    end
  endtask

  task automatic test_stall();
    logic [38:0] exp;
    run_burst(4'hA, 32'h2000_0000, 8'd7, 3'b010, 2'b01, 1'b1);
    vectors++;
    if (timeout || bd.size() != 8 || unstable != 0 || arready_bad != 0) begin
      miscompares++;
      $display("FAIL stall_summary: got beats=%0d timeout=%0b unstable=%0d arready_hi=%0d want 8/0/0/0",
               bd.size(), timeout, unstable, arready_bad);
    end
    for (int i = 0; i < 8 && i < bd.size(); i++) begin
      exp = {4'hA, (i == 7), 2'b00, 32'(32'h1000 + i)};
      vectors++;
      if ({bid[i], bl[i], br[i], bd[i]} !== exp || bcyc[i] != 2 * i + 1) begin
        miscompares++;
        $display("FAIL stall_beat%0d: got %h cyc=%0d want %h cyc=%0d",
                 i, {bid[i], bl[i], br[i], bd[i]}, bcyc[i], exp, 2 * i + 1);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wdata [4];
    logic [38:0] exp;
    wdata[0] = 32'h1002; wdata[1] = 32'h1003; wdata[2] = 32'h1000; wdata[3] = 32'h1001;
    run_burst(4'h2, 32'h2000_0008, 8'd3, 3'b010, 2'b10, 1'b0);
    vectors++;
    if (timeout || bd.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d beats timeout=%0b want 4", bd.size(), timeout);
    end
    for (int i = 0; i < 4 && i < bd.size(); i++) begin
`ifdef SASANQUA_AXI_WRAP_EN
      exp = {4'h2, (i == 3), 2'b00, wdata[i]};
`else
      exp = {4'h2, (i == 3), 2'b10, 32'h0};
`endif
      vectors++;
      if ({bid[i], bl[i], br[i], bd[i]} !== exp) begin
        miscompares++;
        $display("FAIL wrap_beat%0d: got %h want %h", i, {bid[i], bl[i], br[i], bd[i]}, exp);
      end
    end
  endtask

  task automatic test_decerr();
    logic [38:0] exp [4];
    load_word(14'h3FFE, 32'hAAAA_0001);
    load_word(14'h3FFF, 32'hAAAA_0002);
    exp[0] = {4'h7, 1'b0, 2'b00, 32'hAAAA_0001};
    exp[1] = {4'h7, 1'b0, 2'b00, 32'hAAAA_0002};
    exp[2] = {4'h7, 1'b0, 2'b11, 32'h0};
    exp[3] = {4'h7, 1'b1, 2'b11, 32'h0};
    run_burst(4'h7, 32'h2000_FFF8, 8'd3, 3'b010, 2'b01, 1'b0);
    vectors++;
    if (timeout || bd.size() != 4) begin
      miscompares++;
      $display("FAIL decerr_count: got %0d beats timeout=%0b want 4", bd.size(), timeout);
    end
    for (int i = 0; i < 4 && i < bd.size(); i++) begin
      vectors++;
      if ({bid[i], bl[i], br[i], bd[i]} !== exp[i]) begin
        miscompares++;
        $display("FAIL decerr_beat%0d: got %h want %h", i, {bid[i], bl[i], br[i], bd[i]}, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [38:0] exp;
    run_burst(4'h1, 32'h2000_0000, 8'd1, 3'b001, 2'b01, 1'b0);
    vectors++;
    if (timeout || bd.size() != 2) begin
      miscompares++;
      $display("FAIL size_count: got %0d beats timeout=%0b want 2", bd.size(), timeout);
    end
    for (int i = 0; i < 2 && i < bd.size(); i++) begin
      exp = {4'h1, (i == 1), 2'b10, 32'h0};
      vectors++;
      if ({bid[i], bl[i], br[i], bd[i]} !== exp) begin
        miscompares++;
        $display("FAIL size_beat%0d: got %h want %h", i, {bid[i], bl[i], br[i], bd[i]}, exp);
      end
    end
    run_burst(4'hC, 32'h2000_0000, 8'd1, 3'b010, 2'b11, 1'b0);
    vectors++;
    if (timeout || bd.size() != 2 || br[0] !== 2'b10 || br[1] !== 2'b10 ||
        bd[0] !== 32'h0 || bd[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL burst11: got beats=%0d resp0=%b resp1=%b want 2 beats SLVERR data 0",
               bd.size(), br[0], br[1]);
    end
  endtask

  task automatic test_fixed();
    run_burst(4'h4, 32'h2000_0014, 8'd2, 3'b010, 2'b00, 1'b0);
    vectors++;
    if (timeout || bd.size() != 3) begin
      miscompares++;
      $display("FAIL fixed_count: got %0d beats timeout=%0b want 3", bd.size(), timeout);
    end
    for (int i = 0; i < 3 && i < bd.size(); i++) begin
      vectors++;
      if (bd[i] !== 32'h1005 || br[i] !== 2'b00 || bl[i] !== (i == 2)) begin
        miscompares++;
        $display("FAIL fixed_beat%0d: got data=%h resp=%b last=%b want 00001005/00/%0b",
                 i, bd[i], br[i], bl[i], (i == 2));
      end
    end
  endtask

  task automatic test_read_first();
    load_word(14'd10, 32'h0000_1111);
    ARVALID = 1'b1; ARID = 4'h6; ARADDR = 32'h2000_0028; ARLEN = 8'd0;
    ARSIZE = 3'b010; ARBURST = 2'b01;
    LOAD_WE = 1'b1; LOAD_ADDR = 14'd10; LOAD_DATA = 32'h0000_2222;
    @(negedge CLK);
    ARVALID = 1'b0; LOAD_WE = 1'b0; RREADY = 1'b1;
    vectors++;
    if (RVALID !== 1'b1 || RDATA !== 32'h0000_1111 || RLAST !== 1'b1) begin
      miscompares++;
      $display("FAIL read_first_old: got rv=%b data=%h last=%b want 1/00001111/1",
               RVALID, RDATA, RLAST);
    end
    @(negedge CLK);
    RREADY = 1'b0;
    run_burst(4'h6, 32'h2000_0028, 8'd0, 3'b010, 2'b01, 1'b0);
    vectors++;
    if (timeout || bd.size() != 1 || bd[0] !== 32'h0000_2222 || bl[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL read_first_new: got beats=%0d data=%h want 1 beat 00002222",
               bd.size(), bd[0]);
    end
  endtask

  task automatic test_reset_mid();
    vectors++;
    if (ARREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_arready_start: got %b want 1", ARREADY);
    end
    ARVALID = 1'b1; ARID = 4'h3; ARADDR = 32'h2000_0000; ARLEN = 8'd7;
    ARSIZE = 3'b010; ARBURST = 2'b01;
    @(negedge CLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    vectors++;
    if (RDATA !== 32'h1000) begin
      miscompares++;
      $display("FAIL mid_beat0: got %h want 00001000", RDATA);
    end
    @(negedge CLK);
    vectors++;
    if (RDATA !== 32'h1001) begin
      miscompares++;
      $display("FAIL mid_beat1: got %h want 00001001", RDATA);
    end
    @(negedge CLK);
    RST = 1'b1; RREADY = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({ARREADY, RVALID, RLAST, RRESP, RID, RDATA} !== 41'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got ar=%b rv=%b rl=%b resp=%b id=%h data=%h want all 0",
               ARREADY, RVALID, RLAST, RRESP, RID, RDATA);
    end
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if (ARREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_arready_return: got %b want 1", ARREADY);
    end
    run_burst(4'h9, 32'h2000_0000, 8'd3, 3'b010, 2'b01, 1'b0);
    vectors++;
    if (timeout || bd.size() != 4) begin
      miscompares++;
      $display("FAIL mid_rerun_count: got %0d beats timeout=%0b want 4", bd.size(), timeout);
    end
    for (int i = 0; i < 4 && i < bd.size(); i++) begin
      vectors++;
      if (bd[i] !== 32'(32'h1000 + i) || bid[i] !== 4'h9) begin
        miscompares++;
        $display("FAIL mid_rerun_beat%0d: got data=%h id=%h want %h id=9",
                 i, bd[i], bid[i], 32'(32'h1000 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_stall();
    test_wrap();
    test_decerr();
    test_errors();
    test_fixed();
    test_read_first();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_rom_responder.md
# axi_rom_responder

AXI4 read-only slave that serves the core's instruction-fetch burst reads from an on-chip word memory, so riscv-tests images run in synthesizable RTL as well as under the BFM. It sits at the core's instruction AXI master port and implements the responder end of that AR/R protocol. A side-band load port fills the memory with the test binary before or while the core runs.

## Interface
- C_AXI_DATA_WIDTH, 32, R data width; only 32 is supported
- C_AXI_ADDR_WIDTH, 32, AR address width
- C_AXI_ID_WIDTH, 4, ARID/RID width
- C_OFFSET_WIDTH, 16, log2 of memory size in bytes (64 KiB)
- C_BASE_ADDR, 32'h2000_0000, byte address of memory word 0

- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- ARVALID  in  1  / ARREADY  out  1  AR handshake
- ARID  in  C_AXI_ID_WIDTH; ARADDR  in  C_AXI_ADDR_WIDTH; ARLEN  in  8; ARSIZE  in  3; ARBURST  in  2
- RVALID  out  1  / RREADY  in  1  R handshake
- RID  out  C_AXI_ID_WIDTH; RDATA  out  32; RRESP  out  2; RLAST  out  1
- LOAD_WE  in  1  word write strobe
- LOAD_ADDR  in  C_OFFSET_WIDTH-2  word index
- LOAD_DATA  in  32  word data

## Operation
- States: IDLE, BURST.
- IDLE: ARREADY=1. On ARVALID&ARREADY, capture ID, ADDR, LEN, SIZE, BURST, and issue the RAM read of ARADDR in the same cycle. Move to BURST. Beat counter = ARLEN.
- BURST: ARREADY=0 and RVALID=1. RDATA/RRESP/RLAST are held stable while RREADY=0. On each beat handshake that is not the last, compute the next address and read it. RLAST=1 when the beat counter is 0. The last handshake returns the block to IDLE.
- Next address by burst type:
  - FIXED (00): address unchanged.
  - INCR (01): address + 4.
  - WRAP (10): see Configuration.
  - 11: RRESP=SLVERR (2'b10) on every beat; data 0.
- ARSIZE != 3'b010: SLVERR on all beats, RDATA=0. The beat count is still ARLEN+1.
- Decode error: a beat whose address is outside [C_BASE_ADDR, C_BASE_ADDR + 2^C_OFFSET_WIDTH) gets RRESP=DECERR (2'b11) and RDATA=0. This is checked per beat, so an INCR burst that crosses the top of memory errors only on the beats past the end.
- Low two address bits are ignored for the RAM index.
- Load port: writes take effect at the clock edge. A same-cycle read of the same word returns the old data (read-first). Loading during a burst is legal.
- RID equals the captured ARID for every beat.

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, state IDLE. ARREADY rises the first cycle after RST deasserts.
- Latency: AR handshake at edge N gives the first beat RVALID=1 at N+1.
- Throughput is 1 beat/cycle with RREADY held high. A beat handshake at edge M presents the next beat at M+1.
- After the RLAST handshake at edge M, ARREADY=1 from M+1. There is no overlap between bursts.
- RST asserted mid-burst aborts the burst at the next edge. All outputs return to reset values, and memory contents are preserved.
- ARLEN=0 gives a single beat with RLAST=1.

## Configuration
- SASANQUA_AXI_WRAP_EN defined:
  - WRAP bursts with ARLEN in {1,3,7,15} wrap at a boundary of (ARLEN+1)*4 bytes.
  - WRAP with any other ARLEN gets SLVERR on all beats.
- Undefined: every WRAP burst returns SLVERR on all beats with RDATA=0. The wrap-address logic is not compiled.

## Structure
- Shared package holds:
  - burst encodings BURST_FIXED/INCR/WRAP
  - response encodings RESP_OKAY/SLVERR/DECERR
  - state enum
  - the supported ARSIZE constant
- One sub-module, axi_rom_ram: a single-port read plus single-port write word RAM with read-first, 1-cycle synchronous read.
- The top level holds the FSM, address generator, and error checks.

## Test plan
- Load words 0..7 with 0x1000+i. INCR, ARADDR=0x2000_0000, ARLEN=7, RREADY=1 -> data 0x1000..0x1007 on 8 consecutive cycles starting 1 cycle after AR, OKAY, RLAST on beat 8 only.
- Same burst with RREADY toggling 1/0 -> each beat held stable while stalled, same data sequence, ARREADY low until after RLAST.
- WRAP, ARADDR=0x2000_0008, ARLEN=3, macro on -> words 2,3,0,1. Macro off -> 4 beats of SLVERR with data 0.
- INCR, ARADDR=0x2000_FFF8, ARLEN=3 -> beats 1-2 OKAY, beats 3-4 DECERR with data 0.
- ARSIZE=3'b001, ARLEN=1 -> two SLVERR beats, second with RLAST. A FIXED burst with ARLEN=2 at word 5 -> word 5 three times.
- RST for 1 cycle after beat 2 of an 8-beat burst -> RVALID=0 the next cycle, ARREADY=1 one cycle after RST falls, a new burst reads the preserved data.
